wb_arbiter: RTL
===============

# wb_arbiter

Round-robin Wishbone classic-cycle arbiter sharing one slave port among `NUM_MASTERS` bus masters. It sits between the wbmaster instances and the shared slave interconnect. It grants the bus for an entire `cyc` (single or block transfer). A watchdog terminates stalled transfers with `err`.

## Interface
- `NUM_MASTERS`, 4: number of requesting masters (2..8).
- `ADR_W`, 32: address width (`ADR_MSB+1`).
- `DAT_W`, 32: data width (`DATA_MSB+1`).
- `SEL_W`, 4: byte-select width (`SEL_MSB+1`).
- `TIMEOUT`, 255: cycles `s_stb_o` may wait for `ack/err/rty`; 0 disables the watchdog.

One clock; reset is asynchronous and active-low. Ports:
- `clk_i`  in  1  system clock, all state on rising edge.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  NUM_MASTERS each  per-master cycle, strobe and write enable.
- `m_adr_i`  in  NUM_MASTERS*ADR_W  master k at bits [k*ADR_W +: ADR_W].
- `m_sel_i`  in  NUM_MASTERS*SEL_W  packed as `m_adr_i`.
- `m_dat_i`  in  NUM_MASTERS*DAT_W  write data, packed as `m_adr_i`.
- `m_dat_o`  out  DAT_W  read data `s_dat_i` broadcast to all masters.
- `m_ack_o`, `m_err_o`, `m_rty_o`  out  NUM_MASTERS  per-master termination.
- `gnt_o`  out  NUM_MASTERS  one-hot registered grant (all-zero when idle).
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave-side cycle, strobe and write enable.
- `s_adr_o`  out  ADR_W  slave-side address.
- `s_sel_o`  out  SEL_W  slave-side byte select.
- `s_dat_o`  out  DAT_W  slave-side write data.
- `s_dat_i`  in  DAT_W  slave read data.
- `s_ack_i`, `s_err_i`, `s_rty_i`  in  1  slave termination.

## Operation
- States: IDLE, GRANT.
- IDLE: `gnt_o`=0 and all `s_*` outputs are 0. If any `m_cyc_i` is high, select the first requester at or after `ptr` (modulo NUM_MASTERS), register its one-hot grant and move to GRANT.
- GRANT, granted master g: `s_cyc_o`=`m_cyc_i[g]`, `s_stb_o`=`m_stb_i[g]` (subject to watchdog), and `s_we_o/adr/sel/dat` = master g's signals, muxed combinationally from the registered grant.
- `m_ack_o[g]`=`s_ack_i`, `m_err_o[g]`=`s_err_i|wd_err`, `m_rty_o[g]`=`s_rty_i`. All other masters' terminations are 0.
- Leaving GRANT: sampling `m_cyc_i[g]`=0 at a clock edge gives IDLE, `gnt_o`=0, `ptr`=(g+1) mod NUM_MASTERS. Grant never changes while `m_cyc_i[g]`=1, so block transfers keep the bus.
- Watchdog: `wd_cnt` (width clog2(TIMEOUT+1)) increments each GRANT cycle with `s_stb_o`=1 and no slave termination, and clears on any termination, on `m_stb_i[g]`=0, or on leaving GRANT.
- Watchdog trip: when `wd_cnt`==TIMEOUT, `wd_err`=1 for that cycle, `s_stb_o` is forced to 0 for that cycle, and the counter clears.
- Simultaneous slave `ack` and `wd_err` in one cycle: ack has priority and `wd_err` is suppressed.
- Termination with `m_stb_i` low is not forwarded. Slave terminations during IDLE are ignored.

## Timing
- Reset: state=IDLE, `gnt_o`=0, `ptr`=0, `wd_cnt`=0. All `s_*` outputs and `m_ack/err/rty_o` are 0, and `m_dat_o` follows `s_dat_i`.
- Reset mid-transfer: slave-side outputs drop asynchronously with `rst_n_i` low.
- Grant latency: 1 cycle from `m_cyc_i` high in IDLE to `gnt_o`/`s_cyc_o` high.
- Handoff: one dead IDLE cycle between consecutive grants.
- Termination path master <-> slave is combinational (zero added latency), so wbmaster's classic handshake is unchanged.
- Watchdog trips on cycle TIMEOUT+1 of a stalled strobe.

## Structure
- Shared package `wb_pkg`: `ADR_W`/`DAT_W`/`SEL_W` defaults (matching `def.v`) and state encoding constants `ST_IDLE`, `ST_GRANT`.
- One sub-module `rr_pick`: combinational round-robin priority picker with inputs (req vector, ptr) and output one-hot grant. It is reusable by other arbiters.
- The grant-indexed muxes and the watchdog stay in `wb_arbiter`.

## Test plan
- Single requester: master 2 writes adr 0x10, dat 0xA5A5A5A5, slave acks on the third wait cycle. Expect `gnt_o`=0100 one cycle after `cyc`, `s_adr_o`=0x10, `s_dat_o`=0xA5A5A5A5, `m_ack_o[2]` pulse, other acks 0.
- All four `m_cyc_i` high continuously, each releasing after one acked transfer. Expect grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- Master 1 runs a two-beat block read while master 0 requests. Expect `gnt_o` held at 0010 through both acks and master 0 granted only after `m_cyc_i[1]` falls.
- TIMEOUT=4, slave never responds. Expect `m_err_o[g]`=1 on the fifth strobe cycle, `s_stb_o`=0 that cycle, and `wd_cnt` back to 0.
- Slave acks on the same cycle the watchdog would trip (TIMEOUT=4, ack on the fifth cycle). Expect `ack`=1, `err`=0.
- `rst_n_i` asserted mid-transfer. Expect `s_cyc_o`/`s_stb_o`=0 immediately. After release, expect `gnt_o`=0 and the first grant going to the lowest requester at or after index 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone defaults, arbiter state encoding and a small modular-increment helper.
// Pure declarations; no logic or state.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of master-side and slave-side Wishbone signals around the arbiter.
// slave modport is the arbiter's view; master modport is the surrounding system's view.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADR_W       = WB_ADR_W,
  parameter int DAT_W       = WB_DAT_W,
  parameter int SEL_W       = WB_SEL_W
);

  logic [NUM_MASTERS-1:0]       m_cyc_i;
  logic [NUM_MASTERS-1:0]       m_stb_i;
  logic [NUM_MASTERS-1:0]       m_we_i;
  logic [NUM_MASTERS*ADR_W-1:0] m_adr_i;
  logic [NUM_MASTERS*SEL_W-1:0] m_sel_i;
  logic [NUM_MASTERS*DAT_W-1:0] m_dat_i;
  logic [DAT_W-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]       m_ack_o;
  logic [NUM_MASTERS-1:0]       m_err_o;
  logic [NUM_MASTERS-1:0]       m_rty_o;
  logic [NUM_MASTERS-1:0]       gnt_o;
  logic                         s_cyc_o;
  logic                         s_stb_o;
  logic                         s_we_o;
  logic [ADR_W-1:0]             s_adr_o;
  logic [SEL_W-1:0]             s_sel_o;
  logic [DAT_W-1:0]             s_dat_o;
  logic [DAT_W-1:0]             s_dat_i;
  logic                         s_ack_i;
  logic                         s_err_i;
  logic                         s_rty_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o, gnt_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o, gnt_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first request at or after ptr_i.
// Zero latency; all-zero output when nothing is requesting.
module rr_pick #(
  parameter int N = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;
  int               sum;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr_i) + i;
      if (sum >= N) sum = sum - N;
      idx = PTR_W'(sum);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter holding the bus for a whole cyc; grant 1 cycle after request.
// Terminations pass through combinationally; a watchdog ends strobes stalled for TIMEOUT cycles with err.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADR_W       = WB_ADR_W,
  parameter int DAT_W       = WB_DAT_W,
  parameter int SEL_W       = WB_SEL_W,
  parameter int TIMEOUT     = 255
) (
  input logic         clk_i,
  input logic         rst_n_i,
  wb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_MASTERS);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d, pick;
  logic [PTR_W-1:0]       ptr_q, ptr_d, g_idx;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
  logic                   granted, g_cyc, g_stb, s_term, s_stb, wd_err;

  logic [ADR_W-1:0] adr_arr [NUM_MASTERS];
  logic [SEL_W-1:0] sel_arr [NUM_MASTERS];
  logic [DAT_W-1:0] dat_arr [NUM_MASTERS];

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i (bus.m_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) g_idx = PTR_W'(i);
      adr_arr[i] = bus.m_adr_i[i*ADR_W +: ADR_W];
      sel_arr[i] = bus.m_sel_i[i*SEL_W +: SEL_W];
      dat_arr[i] = bus.m_dat_i[i*DAT_W +: DAT_W];
    end
  end

  assign granted = (state_q == ST_GRANT);
  assign g_cyc   = bus.m_cyc_i[g_idx];
  assign g_stb   = bus.m_stb_i[g_idx];
  assign s_term  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  // A real slave termination in the trip cycle wins over the watchdog.
  assign wd_err = (TIMEOUT != 0) && granted && g_stb && !s_term && (wd_cnt_q == WD_MAX);
  assign s_stb  = granted && g_stb && !wd_err;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    wd_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.m_cyc_i) begin
          state_d = ST_GRANT;
          gnt_d   = pick;
        end
      end
      ST_GRANT: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = PTR_W'(wrap_inc(int'(g_idx), NUM_MASTERS));
        end else if (s_stb && !s_term && (TIMEOUT != 0)) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      ptr_q    <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Everything slave-facing is gated by the registered state so reset drops it at once.
  assign bus.gnt_o   = gnt_q;
  assign bus.s_cyc_o = granted && g_cyc;
  assign bus.s_stb_o = s_stb;
  assign bus.s_we_o  = granted && bus.m_we_i[g_idx];
  assign bus.s_adr_o = granted ? adr_arr[g_idx] : '0;
  assign bus.s_sel_o = granted ? sel_arr[g_idx] : '0;
  assign bus.s_dat_o = granted ? dat_arr[g_idx] : '0;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = (granted && g_stb && bus.s_ack_i) ? gnt_q : '0;
  assign bus.m_err_o = (granted && g_stb && (bus.s_err_i || wd_err)) ? gnt_q : '0;
  assign bus.m_rty_o = (granted && g_stb && bus.s_rty_i) ? gnt_q : '0;

endmodule
